// File: rtl/analizador_secuencia_pkg.sv
// analizador_secuencia_pkg
//   Shared definitions for the sequence analyser slice:
//   - FSM state codes (ESPERA / P0_OK / P1_OK), exported on the estado port.
//   - Default target sequence values.
//   - Active-low hex font for a {g,f,e,d,c,b,a} 7-segment digit.
package analizador_secuencia_pkg;

    localparam logic [1:0] ESPERA = 2'b00;
    localparam logic [1:0] P0_OK  = 2'b01;
    localparam logic [1:0] P1_OK  = 2'b10;

    localparam logic [3:0] SEQ_P0_DEF = 4'hA;
    localparam logic [3:0] SEQ_P1_DEF = 4'h5;
    localparam logic [3:0] SEQ_P2_DEF = 4'hA;

    // Index i holds the segment pattern for hex digit i (entry 15 listed first).
    localparam logic [15:0][6:0] SEG_FONT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/analizador_secuencia_if.sv
// analizador_secuencia_if
//   Bundles the sample input and all observation outputs of the analyser.
//   master: the environment (drives en/F, observes results).
//   slave : analizador_secuencia (consumes en/F, drives results).
//   Signals:
//     en          sample enable
//     F[0:3]      upstream value, F[0] is the MSB
//     valor[0:3]  registered last sample
//     cambio      pulse: new sample differs from previous one
//     acierto     pulse: target sequence completed
//     estado      FSM state code
//     n_cambios   wrapping change counter (CW bits)
//     n_aciertos  saturating match counter (AW bits)
//     seg         active-low {g,f,e,d,c,b,a} of valor
interface analizador_secuencia_if #(
    parameter int CW = 8,
    parameter int AW = 4
);
    logic          en;
    logic [0:3]    F;
    logic [0:3]    valor;
    logic          cambio;
    logic          acierto;
    logic [1:0]    estado;
    logic [CW-1:0] n_cambios;
    logic [AW-1:0] n_aciertos;
    logic [6:0]    seg;

    modport master (
        output en, F,
        input  valor, cambio, acierto, estado, n_cambios, n_aciertos, seg
    );

    modport slave (
        input  en, F,
        output valor, cambio, acierto, estado, n_cambios, n_aciertos, seg
    );
endinterface

// File: rtl/analizador_secuencia_decodificador_7seg.sv
// decodificador_7seg
//   Purely combinational hex to 7-segment decoder, active-low outputs.
//   Ports:
//     digito  in  4  value to show (bit 3 is the MSB)
//     seg     out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module decodificador_7seg
    import analizador_secuencia_pkg::*;
(
    input  logic [3:0] digito,
    output logic [6:0] seg
);
    assign seg = SEG_FONT[digito];
endmodule

// File: rtl/analizador_secuencia.sv
// analizador_secuencia
//   Samples the upstream 4-bit value F on every enabled clock, flags value
//   changes, detects the sequence P0,P1,P2 over successive distinct values,
//   counts changes (wrapping) and matches (saturating) and shows the last
//   sample on a hex 7-segment digit.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  synchronous active-low reset
//     bus    analizador_secuencia_if.slave (en, F in; valor, cambio,
//            acierto, estado, n_cambios, n_aciertos, seg out)
module analizador_secuencia
    import analizador_secuencia_pkg::*;
#(
    parameter logic [3:0] P0 = SEQ_P0_DEF,
    parameter logic [3:0] P1 = SEQ_P1_DEF,
    parameter logic [3:0] P2 = SEQ_P2_DEF,
    parameter int         CW = 8,
    parameter int         AW = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    analizador_secuencia_if.slave   bus
);

    // Equal neighbours in the target sequence can never be seen as an event
    // pair, so the detector would never fire.
    if (P0 == P1 || P1 == P2) begin : g_bad_sequence
        $error("analizador_secuencia: P0==P1 or P1==P2 makes a match impossible");
    end

    logic [3:0]    f_in;
    logic [3:0]    valor_q,      valor_d;
    logic          primero_q,    primero_d;
    logic          cambio_q,     cambio_d;
    logic          acierto_q,    acierto_d;
    logic [1:0]    estado_q,     estado_d;
    logic [CW-1:0] n_cambios_q,  n_cambios_d;
    logic [AW-1:0] n_aciertos_q, n_aciertos_d;
    logic          distinto;
    logic          ev;

    assign f_in     = bus.F;
    assign distinto = (f_in != valor_q);
    // The very first enabled sample is always an event so the FSM sees it,
    // even when it happens to equal the reset value of valor.
    assign ev       = bus.en & (primero_q | distinto);

    always_comb begin
        valor_d      = valor_q;
        primero_d    = primero_q;
        cambio_d     = 1'b0;
        acierto_d    = 1'b0;
        estado_d     = estado_q;
        n_cambios_d  = n_cambios_q;
        n_aciertos_d = n_aciertos_q;

        if (bus.en) begin
            valor_d   = f_in;
            primero_d = 1'b0;
            cambio_d  = distinto & ~primero_q;

            if (ev) begin
                unique case (estado_q)
                    P0_OK: begin
                        if (f_in == P1)      estado_d = P1_OK;
                        else if (f_in == P0) estado_d = P0_OK;
                        else                 estado_d = ESPERA;
                    end
                    P1_OK: begin
                        if (f_in == P2) begin
                            acierto_d = 1'b1;
                            // With P2==P0 the closing value already starts
                            // the next sequence.
                            estado_d  = (P2 == P0) ? P0_OK : ESPERA;
                        end else if (f_in == P0) begin
                            estado_d = P0_OK;
                        end else begin
                            estado_d = ESPERA;
                        end
                    end
                    default: begin
                        if (f_in == P0) estado_d = P0_OK;
                        else            estado_d = ESPERA;
                    end
                endcase
            end

            if (cambio_d) begin
                n_cambios_d = n_cambios_q + 1'b1;
            end
            if (acierto_d && (n_aciertos_q != {AW{1'b1}})) begin
                n_aciertos_d = n_aciertos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valor_q      <= '0;
            primero_q    <= 1'b1;
            cambio_q     <= 1'b0;
            acierto_q    <= 1'b0;
            estado_q     <= ESPERA;
            n_cambios_q  <= '0;
            n_aciertos_q <= '0;
        end else begin
            valor_q      <= valor_d;
            primero_q    <= primero_d;
            cambio_q     <= cambio_d;
            acierto_q    <= acierto_d;
            estado_q     <= estado_d;
            n_cambios_q  <= n_cambios_d;
            n_aciertos_q <= n_aciertos_d;
        end
    end

    decodificador_7seg u_decodificador_7seg (
        .digito (valor_q),
        .seg    (bus.seg)
    );

    assign bus.valor      = valor_q;
    assign bus.cambio     = cambio_q;
    assign bus.acierto    = acierto_q;
    assign bus.estado     = estado_q;
    assign bus.n_cambios  = n_cambios_q;
    assign bus.n_aciertos = n_aciertos_q;

endmodule

// File: tb/tb_analizador_secuencia.sv
module tb_analizador_secuencia;

    localparam logic [3:0] P0 = 4'hA;
    localparam logic [3:0] P1 = 4'h5;
    localparam logic [3:0] P2 = 4'hA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] f_in = 4'h0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    analizador_secuencia_if #(.CW(8), .AW(4)) bus_a ();
    analizador_secuencia_if #(.CW(2), .AW(2)) bus_b ();

    assign bus_a.en = en;
    assign bus_a.F  = f_in;
    assign bus_b.en = en;
    assign bus_b.F  = f_in;

    analizador_secuencia #(.P0(P0), .P1(P1), .P2(P2), .CW(8), .AW(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    analizador_secuencia #(.P0(P0), .P1(P1), .P2(P2), .CW(2), .AW(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // Active-low hex font {g,f,e,d,c,b,a}
    logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: the list of distinct values seen since reset, the
    // position where the last match ended, plus running totals.
    logic [3:0] hist[$];
    int         last_end;
    logic [3:0] m_valor;
    bit         m_primero;
    bit         m_cambio;
    bit         m_acierto;
    int         m_estado;
    int         m_nc;
    int         m_na;
    bit         started = 0;

    always begin
        logic       r, e;
        logic [3:0] v;
        int         k;
        @(posedge clk);
        r = rst_n; e = en; v = f_in;
        if (!r) begin
            hist.delete();
            last_end  = 0;
            m_valor   = 4'h0;
            m_primero = 1;
            m_cambio  = 0;
            m_acierto = 0;
            m_estado  = 0;
            m_nc      = 0;
            m_na      = 0;
            started   = 1;
        end else if (!e) begin
            m_cambio  = 0;
            m_acierto = 0;
        end else begin
            m_cambio  = !m_primero && (v != m_valor);
            m_acierto = 0;
            if (m_primero || v != m_valor) begin
                hist.push_back(v);
                k = hist.size() - 1;
                if (k >= 2 && hist[k-2] == P0 && hist[k-1] == P1 && v == P2 && k - 2 >= last_end) begin
                    m_acierto = 1;
                    last_end  = k;
                    m_estado  = (P2 == P0) ? 1 : 0;
                end else if (k >= 1 && hist[k-1] == P0 && v == P1 && k - 1 >= last_end) begin
                    m_estado = 2;
                end else if (v == P0) begin
                    m_estado = 1;
                end else begin
                    m_estado = 0;
                end
            end
            m_valor   = v;
            m_primero = 0;
            m_nc += int'(m_cambio);
            m_na += int'(m_acierto);
        end
        #1;
        if (started) begin
            chk("valor",        int'(bus_a.valor),      int'(m_valor));
            chk("cambio",       int'(bus_a.cambio),     int'(m_cambio));
            chk("acierto",      int'(bus_a.acierto),    int'(m_acierto));
            chk("estado",       int'(bus_a.estado),     m_estado);
            chk("seg",          int'(bus_a.seg),        int'(font[m_valor]));
            chk("n_cambios",    int'(bus_a.n_cambios),  m_nc % 256);
            chk("n_aciertos",   int'(bus_a.n_aciertos), (m_na > 15) ? 15 : m_na);
            chk("b_valor",      int'(bus_b.valor),      int'(m_valor));
            chk("b_n_cambios",  int'(bus_b.n_cambios),  m_nc % 4);
            chk("b_n_aciertos", int'(bus_b.n_aciertos), (m_na > 3) ? 3 : m_na);
        end
    end

    task automatic step(input logic r, input logic e, input logic [3:0] v);
        @(negedge clk);
        rst_n = r;
        en    = e;
        f_in  = v;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 4'h0);
    endtask

    initial begin
        // Reset held three edges with F=7
        rst_n = 1'b0; en = 1'b1; f_in = 4'h7;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h7);
        chk("lit_rst_valor", int'(bus_a.valor), 0);
        chk("lit_rst_seg",   int'(bus_a.seg),   7'b1000000);
        chk("lit_rst_nc",    int'(bus_a.n_cambios), 0);
        chk("lit_rst_na",    int'(bus_a.n_aciertos), 0);
        step(1'b1, 1'b1, 4'h7);
        chk("lit_rel_valor",  int'(bus_a.valor),  7);
        chk("lit_rel_cambio", int'(bus_a.cambio), 0);
        chk("lit_rel_estado", int'(bus_a.estado), 0);
        chk("lit_rel_seg",    int'(bus_a.seg),    7'b1111000);

        // Basic match A,5,A
        do_reset();
        step(1'b1, 1'b1, 4'hA);
        chk("lit_m1_estado", int'(bus_a.estado), 1);
        chk("lit_m1_seg",    int'(bus_a.seg),    7'b0001000);
        step(1'b1, 1'b1, 4'h5);
        chk("lit_m2_estado",  int'(bus_a.estado),  2);
        chk("lit_m2_acierto", int'(bus_a.acierto), 0);
        chk("lit_m2_seg",     int'(bus_a.seg),     7'b0010010);
        step(1'b1, 1'b1, 4'hA);
        chk("lit_m3_estado",  int'(bus_a.estado),     1);
        chk("lit_m3_acierto", int'(bus_a.acierto),    1);
        chk("lit_m3_na",      int'(bus_a.n_aciertos), 1);
        chk("lit_m3_nc",      int'(bus_a.n_cambios),  2);
        step(1'b1, 1'b1, 4'hA);
        chk("lit_m4_acierto", int'(bus_a.acierto), 0);

        // Overlap A,5,A,5,A
        do_reset();
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'hA);
        chk("lit_ov3_acierto", int'(bus_a.acierto), 1);
        step(1'b1, 1'b1, 4'h5);
        chk("lit_ov4_acierto", int'(bus_a.acierto), 0);
        step(1'b1, 1'b1, 4'hA);
        chk("lit_ov5_acierto", int'(bus_a.acierto),    1);
        chk("lit_ov5_na",      int'(bus_a.n_aciertos), 2);
        chk("lit_ov5_nc",      int'(bus_a.n_cambios),  4);

        // Break and hold: A,5,3,A then A held
        do_reset();
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'h3);
        chk("lit_br_estado", int'(bus_a.estado), 0);
        chk("lit_br_seg",    int'(bus_a.seg),    7'b0110000);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'hA);
        chk("lit_hold_estado", int'(bus_a.estado),     1);
        chk("lit_hold_cambio", int'(bus_a.cambio),     0);
        chk("lit_hold_nc",     int'(bus_a.n_cambios),  3);
        chk("lit_hold_na",     int'(bus_a.n_aciertos), 0);
        step(1'b1, 1'b1, 4'hF);
        chk("lit_f_seg", int'(bus_a.seg), 7'b0001110);

        // Enable low then mid-sequence reset
        do_reset();
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b0, 4'hA);
        step(1'b1, 1'b0, 4'hA);
        chk("lit_en_estado", int'(bus_a.estado),  2);
        chk("lit_en_cambio", int'(bus_a.cambio),  0);
        chk("lit_en_valor",  int'(bus_a.valor),   5);
        chk("lit_en_ac",     int'(bus_a.acierto), 0);
        step(1'b0, 1'b1, 4'hA);
        chk("lit_mr_estado", int'(bus_a.estado), 0);
        step(1'b1, 1'b1, 4'hA);
        chk("lit_mr2_estado", int'(bus_a.estado), 1);
        chk("lit_mr2_cambio", int'(bus_a.cambio), 0);

        // Counter limits: five changes then four matches in total
        do_reset();
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h5);
        chk("lit_lim_b_nc", int'(bus_b.n_cambios), 1);
        chk("lit_lim_a_nc", int'(bus_a.n_cambios), 5);
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'hA);
        chk("lit_lim_a_na", int'(bus_a.n_aciertos), 4);
        chk("lit_lim_b_na", int'(bus_b.n_aciertos), 3);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'hA);
        chk("lit_sat_b_na", int'(bus_b.n_aciertos), 3);
        chk("lit_sat_a_na", int'(bus_a.n_aciertos), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
